dp_data_ram_v2: RTL and testbench



---
 rtl/dp_data_ram_v2_if.sv | 32 +++
 rtl/dp_data_ram_v2.sv | 108 ++++++++++
 tb/tb_dp_data_ram_v2.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_data_ram_v2_if.sv
`timescale 1ns/1ps
// Port bundle for the dual-port data RAM: two byte-enabled ports plus ready/collision status.
// The master drives port requests; the slave (RAM) returns read data, ready and coll.
interface dp_data_ram_v2_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    localparam int BYTES = DATA_W / 8;

    logic              ready;
    logic              ena;
    logic [BYTES-1:0]  wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              enb;
    logic [BYTES-1:0]  web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] doutb;
    logic              coll;

    modport master (
        input  ready, douta, doutb, coll,
        output ena, wea, addra, dina, enb, web, addrb, dinb
    );

    modport slave (
        output ready, douta, doutb, coll,
        input  ena, wea, addra, dina, enb, web, addrb, dinb
    );
endinterface

// File: rtl/dp_data_ram_v2.sv
`timescale 1ns/1ps
// True dual-port byte-enabled RAM; read latency 1 (2 with OUT_REG), selectable read-during-write.
// No backpressure once running; ready stays low through the post-reset clear and all port ops are ignored.
module dp_data_ram_v2 #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WRITE_FIRST = 0,
    parameter int OUT_REG     = 0,
    parameter int INIT_CLEAR  = 1
) (
    input  logic             clk,
    input  logic             rst,
    dp_data_ram_v2_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {CLEAR, RUN_PEND, RUN} state_t;

    state_t            state;
    logic              ready_q;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              go_a, go_b, coll_now, coll_q;
    logic [BYTES-1:0]  wa, wb;
    logic [DATA_W-1:0] old_a, old_b, rd_a, rd_b;
    logic [DATA_W-1:0] s1_a, s1_b, douta_q, doutb_q;
    logic              pend_a, pend_b;

    assign go_a = ready_q & bus.ena;
    assign go_b = ready_q & bus.enb;

    // Same-port write-first only merges the port's own lanes; the other port's
    // write is never visible in this cycle's read data.
    always_comb begin
        wa       = go_a ? bus.wea : '0;
        wb       = go_b ? bus.web : '0;
        old_a    = mem[bus.addra];
        old_b    = mem[bus.addrb];
        rd_a     = old_a;
        rd_b     = old_b;
        for (int i = 0; i < BYTES; i++) begin
            if (WRITE_FIRST != 0 && wa[i]) rd_a[i*8 +: 8] = bus.dina[i*8 +: 8];
            if (WRITE_FIRST != 0 && wb[i]) rd_b[i*8 +: 8] = bus.dinb[i*8 +: 8];
        end
        coll_now = go_a & go_b & (bus.addra == bus.addrb) & ((|wa) | (|wb));
    end

    // Port A lanes are written last so they win any same-lane collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) mem[clr_cnt] <= '0;
            for (int i = 0; i < BYTES; i++)
                if (wb[i]) mem[bus.addrb][i*8 +: 8] <= bus.dinb[i*8 +: 8];
            for (int i = 0; i < BYTES; i++)
                if (wa[i]) mem[bus.addra][i*8 +: 8] <= bus.dina[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (INIT_CLEAR != 0) ? CLEAR : RUN_PEND;
            ready_q <= 1'b0;
            clr_cnt <= '0;
            coll_q  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            pend_a  <= 1'b0;
            pend_b  <= 1'b0;
            douta_q <= '0;
            doutb_q <= '0;
        end else begin
            coll_q <= coll_now;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN_PEND: begin
                    state   <= RUN;
                    ready_q <= 1'b1;
                end
                default: ;
            endcase
            // Second stage advances only for data the first stage actually captured.
            if (OUT_REG != 0) begin
                pend_a <= go_a;
                pend_b <= go_b;
                if (go_a)   s1_a    <= rd_a;
                if (go_b)   s1_b    <= rd_b;
                if (pend_a) douta_q <= s1_a;
                if (pend_b) doutb_q <= s1_b;
            end else begin
                if (go_a) douta_q <= rd_a;
                if (go_b) doutb_q <= rd_b;
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.douta = douta_q;
    assign bus.doutb = doutb_q;
    assign bus.coll  = coll_q;
endmodule

// File: tb/tb_dp_data_ram_v2.sv
`timescale 1ns/1ps
// Scoreboard bench for dp_data_ram_v2: u0 uses defaults (read-first, no out reg, clear),
// u1 uses write-first, output register, no clear and a 16-word array.
module tb_dp_data_ram_v2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dp_data_ram_v2_if #(.DATA_W(32), .ADDR_W(8)) a0 ();
    dp_data_ram_v2_if #(.DATA_W(32), .ADDR_W(4)) a1 ();

    dp_data_ram_v2 #(.DATA_W(32), .ADDR_W(8), .WRITE_FIRST(0), .OUT_REG(0), .INIT_CLEAR(1))
        u0 (.clk(clk), .rst(rst0), .bus(a0));
    dp_data_ram_v2 #(.DATA_W(32), .ADDR_W(4), .WRITE_FIRST(1), .OUT_REG(1), .INIT_CLEAR(0))
        u1 (.clk(clk), .rst(rst1), .bus(a1));

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] probe(int sel);
        case (sel)
            0:       return a0.douta;
            1:       return a0.doutb;
            2:       return {31'b0, a0.coll};
            3:       return {31'b0, a0.ready};
            4:       return a1.douta;
            5:       return a1.doutb;
            6:       return {31'b0, a1.coll};
            default: return {31'b0, a1.ready};
        endcase
    endfunction

    task automatic expect_at(input int lat, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.due = cyc + lat;
        e.sel = sel;
        e.exp = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checks++;
                if (probe(sb[i].sel) !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].nm, probe(sb[i].sel), sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a0(input logic en, input logic [3:0] we, input logic [7:0] ad, input logic [31:0] d);
        a0.ena = en; a0.wea = we; a0.addra = ad; a0.dina = d;
    endtask
    task automatic set_b0(input logic en, input logic [3:0] we, input logic [7:0] ad, input logic [31:0] d);
        a0.enb = en; a0.web = we; a0.addrb = ad; a0.dinb = d;
    endtask
    task automatic set_a1(input logic en, input logic [3:0] we, input logic [3:0] ad, input logic [31:0] d);
        a1.ena = en; a1.wea = we; a1.addra = ad; a1.dina = d;
    endtask
    task automatic set_b1(input logic en, input logic [3:0] we, input logic [3:0] ad, input logic [31:0] d);
        a1.enb = en; a1.web = we; a1.addrb = ad; a1.dinb = d;
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        set_a0(0, 4'h0, 8'd0, 32'h0); set_b0(0, 4'h0, 8'd0, 32'h0);
        set_a1(0, 4'h0, 4'd0, 32'h0); set_b1(0, 4'h0, 4'd0, 32'h0);
        step(); step();
        expect_at(0, 3, 32'h0, "rst_ready0");
        expect_at(0, 0, 32'h0, "rst_douta0");
        expect_at(0, 2, 32'h0, "rst_coll0");
        expect_at(0, 4, 32'h0, "rst_douta1");
        expect_at(0, 7, 32'h0, "rst_ready1");
        step();

        // initial clear; ports driven but must be ignored
        rst0 = 1'b0;
        set_a0(1, 4'hF, 8'd5, 32'hFFFFFFFF);
        set_b0(1, 4'h0, 8'd5, 32'h0);
        expect_at(1,   0, 32'h0, "clr_douta_ignored");
        expect_at(1,   1, 32'h0, "clr_doutb_ignored");
        expect_at(255, 3, 32'h0, "clr_ready_lo_255");
        expect_at(256, 3, 32'h1, "clr_ready_hi_256");
        step();
        set_a0(0, 4'h0, 8'd0, 32'h0); set_b0(0, 4'h0, 8'd0, 32'h0);
        repeat (255) step();

        // preload, then reset and abort the clear at word 100
        set_a0(1, 4'hF, 8'd5, 32'hDEADBEEF); step();
        set_a0(1, 4'h0, 8'd5, 32'h0);
        expect_at(1, 0, 32'hDEADBEEF, "preload_rd5");
        step();
        set_a0(0, 4'h0, 8'd0, 32'h0); step();
        rst0 = 1'b1;
        set_a0(1, 4'hF, 8'd5, 32'h12121212);
        step();
        expect_at(0, 3, 32'h0, "rst_again_ready");
        expect_at(0, 0, 32'h0, "rst_again_douta");
        checks++;
        if (a0.ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_again_ready_direct: got %b expected 0", a0.ready);
        end
        rst0 = 1'b0;
        set_a0(0, 4'h0, 8'd0, 32'h0);
        repeat (100) step();
        rst0 = 1'b1; step(); rst0 = 1'b0;
        expect_at(155, 3, 32'h0, "midclr_ready_lo_156");
        expect_at(255, 3, 32'h0, "midclr_ready_lo_255");
        expect_at(256, 3, 32'h1, "midclr_ready_hi_256");
        repeat (256) step();
        checks++;
        if (a0.ready !== 1'b1) begin
            errors++;
            $display("FAIL midclr_ready_direct: got %b expected 1", a0.ready);
        end
        set_a0(1, 4'h0, 8'd5, 32'h0);
        expect_at(1, 0, 32'h0, "clear_rd5");
        step();

        // byte-lane merge, read-first same port
        set_a0(1, 4'hF, 8'd3, 32'h11223344); step();
        set_a0(1, 4'b0101, 8'd3, 32'hAABBCCDD);
        expect_at(1, 0, 32'h11223344, "rf_same_port_old");
        step();
        set_a0(1, 4'h0, 8'd3, 32'h0);
        expect_at(1, 0, 32'h11BB33DD, "byte_merge");
        step();

        // port B write, read-first
        set_a0(0, 4'h0, 8'd0, 32'h0);
        set_b0(1, 4'hF, 8'd7, 32'hCAFEF00D);
        expect_at(1, 1, 32'h0, "rf_portb_old");
        step();
        set_b0(1, 4'h0, 8'd7, 32'h0);
        expect_at(1, 1, 32'hCAFEF00D, "portb_rd7");
        step();
        set_b0(0, 4'h0, 8'd0, 32'h0);
        expect_at(2, 1, 32'hCAFEF00D, "doutb_hold");
        step(); step();

        // same-address collision
        set_a0(1, 4'b0011, 8'd9, 32'h0000AAAA);
        set_b0(1, 4'b0110, 8'd9, 32'h00BBBB00);
        expect_at(1, 2, 32'h1, "coll_hi");
        expect_at(2, 2, 32'h0, "coll_lo");
        expect_at(1, 0, 32'h0, "coll_rd_a_old");
        expect_at(1, 1, 32'h0, "coll_rd_b_old");
        step();
        set_a0(1, 4'h0, 8'd9, 32'h0);
        set_b0(1, 4'h0, 8'd9, 32'h0);
        expect_at(1, 0, 32'h00BBAAAA, "coll_merge");
        expect_at(1, 2, 32'h0, "rd_rd_nocoll");
        step();
        set_a0(1, 4'hF, 8'd10, 32'h11111111);
        set_b0(1, 4'hF, 8'd10, 32'h22222222);
        step();
        set_a0(1, 4'h0, 8'd10, 32'h0);
        set_b0(0, 4'h0, 8'd0, 32'h0);
        expect_at(1, 0, 32'h11111111, "coll_a_wins");
        step();
        set_a0(0, 4'h0, 8'd0, 32'h0);
        step();

        // u1: no-clear bring-up, op in the pending cycle is dropped
        rst1 = 1'b0;
        expect_at(1, 7, 32'h1, "runpend_ready");
        set_a1(1, 4'hF, 4'd1, 32'h77777777);
        step();
        set_a1(1, 4'hF, 4'd1, 32'h01010101); step();
        set_a1(0, 4'h0, 4'd0, 32'h0); step(); step();
        rst1 = 1'b1;
        set_a1(1, 4'hF, 4'd1, 32'h55555555);
        step();
        rst1 = 1'b0;
        expect_at(0, 4, 32'h0, "rst1_douta");
        expect_at(0, 7, 32'h0, "rst1_ready");
        set_a1(1, 4'hF, 4'd1, 32'h77777777);
        step();
        set_a1(1, 4'h0, 4'd1, 32'h0);
        expect_at(2, 4, 32'h01010101, "rst_edge_discard");
        step();
        set_a1(0, 4'h0, 4'd0, 32'h0); step(); step();

        // write-first with output register
        set_a1(1, 4'hF, 4'd2, 32'h12345678);
        expect_at(2, 4, 32'h12345678, "wf_full");
        step();
        set_a1(1, 4'hF, 4'd4, 32'h00004444);
        expect_at(2, 4, 32'h00004444, "wf_full4");
        step();
        set_a1(1, 4'b0011, 4'd4, 32'h1234AAAA);
        expect_at(2, 4, 32'h0000AAAA, "wf_merge");
        step();
        set_a1(0, 4'h0, 4'd0, 32'h0); step(); step();
        set_a1(1, 4'h0, 4'd2, 32'h0);
        expect_at(1, 4, 32'h0000AAAA, "oreg_stage_old");
        expect_at(2, 4, 32'h12345678, "oreg_lat2");
        step();
        set_a1(0, 4'h0, 4'd0, 32'h0);
        expect_at(3, 4, 32'h12345678, "oreg_hold");
        step(); step(); step();
        checks++;
        if (a1.douta !== 32'h12345678) begin
            errors++;
            $display("FAIL oreg_hold_direct: got %h expected 12345678", a1.douta);
        end

        set_b1(1, 4'hF, 4'd7, 32'hCAFEF00D);
        expect_at(2, 5, 32'hCAFEF00D, "wf_portb");
        step();
        set_b1(1, 4'h0, 4'd7, 32'h0);
        expect_at(2, 5, 32'hCAFEF00D, "wf_portb_rd7");
        step();
        set_b1(0, 4'h0, 4'd0, 32'h0); step(); step();

        // cross-port write: other port sees the old word even in write-first
        set_a1(1, 4'hF, 4'd2, 32'h99999999);
        set_b1(1, 4'h0, 4'd2, 32'h0);
        expect_at(2, 5, 32'h12345678, "xport_old");
        expect_at(2, 4, 32'h99999999, "xport_own_wf");
        expect_at(1, 6, 32'h1, "coll1_hi");
        expect_at(2, 6, 32'h0, "coll1_lo");
        step();
        set_a1(0, 4'h0, 4'd0, 32'h0); set_b1(0, 4'h0, 4'd0, 32'h0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: never sampled, expected %h", sb[0].nm, sb[0].exp);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
